// File: rtl/div_controller.sv
// div_controller: sequences DIV/DIVU requests through an external unsigned
// restoring divider. It screens divide-by-zero, converts signed operands to
// magnitudes, runs a watchdog while the divider works, applies the sign
// fix-up and holds the architectural HI/LO results.
module div_controller #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DIV_REQ,
  input  logic        DIV_SIGNED,
  input  logic [31:0] RS,
  input  logic [31:0] RT,
  output logic        DIV_START,
  output logic [31:0] DIV_A,
  output logic [31:0] DIV_B,
  input  logic        DIV_END,
  input  logic [31:0] DIV_HI,
  input  logic [31:0] DIV_LO,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV_ZERO,
  output logic        DIV_TIMEOUT
);

  localparam int unsigned      DATA_W   = 32;
  localparam int unsigned      TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [TMR_W-1:0]  timer_q,   timer_d;
  logic              sa_q,      sa_d;
  logic              sb_q,      sb_d;
  logic [DATA_W-1:0] div_a_q,   div_a_d;
  logic [DATA_W-1:0] div_b_q,   div_b_d;
  logic [DATA_W-1:0] hi_q,      hi_d;
  logic [DATA_W-1:0] lo_q,      lo_d;
  logic              start_q,   start_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              zero_q,    zero_d;
  logic              tout_q,    tout_d;

  // 32-bit two's-complement negate; wraps for 0x80000000
  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    tout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (DIV_REQ) begin
          if (RT == '0) begin
            // divide-by-zero is reported without ever starting the divider
            zero_d = 1'b1;
          end else begin
            sa_d    = DIV_SIGNED & RS[DATA_W-1];
            sb_d    = DIV_SIGNED & RT[DATA_W-1];
            div_a_d = (DIV_SIGNED & RS[DATA_W-1]) ? neg32(RS) : RS;
            div_b_d = (DIV_SIGNED & RT[DATA_W-1]) ? neg32(RT) : RT;
            start_d = 1'b1;
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // a completion on the final watchdog edge still counts as done
        if (DIV_END) begin
          state_d = ST_FIX;
        end else if (timer_q == TMR_LAST) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FIX: begin
        // quotient negative when signs differ; remainder follows dividend
        lo_d    = (sa_q ^ sb_q) ? neg32(DIV_LO) : DIV_LO;
        hi_d    = sa_q ? neg32(DIV_HI) : DIV_HI;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign DIV_START   = start_q;
  assign DIV_A       = div_a_q;
  assign DIV_B       = div_b_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign DIV_ZERO    = zero_q;
  assign DIV_TIMEOUT = tout_q;

endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: directed bench for div_controller with a latency-
// programmable divider model and an event-schedule reference model.
module tb_div_controller;

  localparam int unsigned TMO = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        DIV_REQ = 1'b0;
  logic        DIV_SIGNED = 1'b0;
  logic [31:0] RS = '0;
  logic [31:0] RT = '0;
  logic        DIV_START;
  logic [31:0] DIV_A;
  logic [31:0] DIV_B;
  logic        DIV_END = 1'b0;
  logic [31:0] DIV_HI = '0;
  logic [31:0] DIV_LO = '0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;
  logic        DIV_ZERO;
  logic        DIV_TIMEOUT;

  div_controller #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .DIV_REQ(DIV_REQ), .DIV_SIGNED(DIV_SIGNED), .RS(RS), .RT(RT),
    .DIV_START(DIV_START), .DIV_A(DIV_A), .DIV_B(DIV_B),
    .DIV_END(DIV_END), .DIV_HI(DIV_HI), .DIV_LO(DIV_LO),
    .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE),
    .DIV_ZERO(DIV_ZERO), .DIV_TIMEOUT(DIV_TIMEOUT)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad   = 0;

  // Divider model: raises DIV_END L edges after it samples DIV_START
  int          div_lat  = 1;
  bit          div_hang = 1'b0;
  logic [31:0] d_a = '0, d_b = '0;
  int          d_cnt = 0;
  bit          d_run = 1'b0;
  always @(posedge clock) begin
    if (DIV_START) begin
      d_a     <= DIV_A;
      d_b     <= DIV_B;
      d_cnt   <= div_lat;
      d_run   <= !div_hang;
      DIV_END <= 1'b0;
    end else if (d_run) begin
      if (d_cnt <= 1) begin
        DIV_END <= 1'b1;
        DIV_LO  <= d_a / d_b;
        DIV_HI  <= d_a % d_b;
        d_run   <= 1'b0;
      end else begin
        d_cnt <= d_cnt - 1;
      end
    end
  end

  // Reference schedule: cycle numbers (posedge counts) at which events appear
  int start_cyc, done_cyc, zero_cyc, tout_cyc, busy_from, busy_to;
  logic [31:0] hi_old, hi_new, lo_old, lo_new, a_old, a_new, b_old, b_new;
  int hi_from, a_from;
  int last_done_cyc = -1;
  int last_tout_cyc = -1;

  task automatic model_reset();
    start_cyc = -1; done_cyc = -1; zero_cyc = -1; tout_cyc = -1;
    busy_from = -1; busy_to = -1;
    hi_old = '0; hi_new = '0; lo_old = '0; lo_new = '0; hi_from = -1;
    a_old = '0; a_new = '0; b_old = '0; b_new = '0; a_from = -1;
  endtask

  function automatic logic [31:0] cur_hi(); return (cyc >= hi_from) ? hi_new : hi_old; endfunction
  function automatic logic [31:0] cur_lo(); return (cyc >= hi_from) ? lo_new : lo_old; endfunction
  function automatic logic [31:0] cur_a();  return (cyc >= a_from)  ? a_new  : a_old;  endfunction
  function automatic logic [31:0] cur_b();  return (cyc >= a_from)  ? b_new  : b_old;  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural result from plain arithmetic (truncating division)
  task automatic compute(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [31:0] a, output logic [31:0] b);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(rs));
      y = longint'($signed(rt));
      q = 32'(x / y);
      r = 32'(x % y);
      a = 32'((x < 0) ? -x : x);
      b = 32'((y < 0) ? -y : y);
    end else begin
      q = rs / rt;
      r = rs % rt;
      a = rs;
      b = rt;
    end
  endtask

  // Per-cycle comparison against the schedule
  always @(negedge clock) begin
    if (reset) begin
      chk("DIV_START",   32'(DIV_START),   32'(cyc == start_cyc));
      chk("DONE",        32'(DONE),        32'(cyc == done_cyc));
      chk("DIV_ZERO",    32'(DIV_ZERO),    32'(cyc == zero_cyc));
      chk("DIV_TIMEOUT", 32'(DIV_TIMEOUT), 32'(cyc == tout_cyc));
      chk("BUSY",        32'(BUSY),        32'((cyc >= busy_from) && (cyc < busy_to)));
      chk("HI",          HI,               cur_hi());
      chk("LO",          LO,               cur_lo());
      chk("DIV_A",       DIV_A,            cur_a());
      chk("DIV_B",       DIV_B,            cur_b());
      if (DONE === 1'b1)        last_done_cyc = cyc;
      if (DIV_TIMEOUT === 1'b1) last_tout_cyc = cyc;
    end
  end

  // Drive one request cycle and schedule its expected effects; e = sampling edge
  task automatic issue(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                       input int lat, input bit hang, output int e, output int end_c);
    logic [31:0] q, r, a, b;
    @(posedge clock); #1;
    e = cyc + 1;
    hi_old = cur_hi(); lo_old = cur_lo(); a_old = cur_a(); b_old = cur_b();
    hi_new = hi_old;   lo_new = lo_old;   a_new = a_old;   b_new = b_old;
    if (rt == '0) begin
      zero_cyc = e;
      end_c    = e + 1;
    end else begin
      compute(sgn, rs, rt, q, r, a, b);
      start_cyc = e; busy_from = e;
      a_new = a; b_new = b; a_from = e;
      if (hang) begin
        tout_cyc = e + 1 + TMO;
        busy_to  = tout_cyc;
      end else begin
        done_cyc = e + 3 + lat;
        busy_to  = e + 4 + lat;
        hi_new = r; lo_new = q; hi_from = done_cyc;
      end
      end_c = busy_to + 1;
    end
    div_lat = lat; div_hang = hang;
    DIV_REQ = 1'b1; DIV_SIGNED = sgn; RS = rs; RT = rt;
    @(posedge clock); #1;
    DIV_REQ = 1'b0; DIV_SIGNED = 1'b0; RS = 32'hDEADBEEF; RT = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clock);
    #1;
  endtask

  task automatic pulse_req(input logic sgn, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clock); #1;
    DIV_REQ = 1'b1; DIV_SIGNED = sgn; RS = rs; RT = rt;
    @(posedge clock); #1;
    DIV_REQ = 1'b0; DIV_SIGNED = 1'b0; RT = '0;
  endtask

  initial begin
    int e, ec;
    model_reset();

    // reset state
    #12;
    chk("rst HI", HI, 32'h0);
    chk("rst LO", LO, 32'h0);
    chk("rst BUSY", 32'(BUSY), 32'h0);
    chk("rst DIV_START", 32'(DIV_START), 32'h0);
    chk("rst DIV_A", DIV_A, 32'h0);
    @(posedge clock); #2; reset = 1'b1;

    // DIVU 100/7, L=3
    issue(1'b0, 32'd100, 32'd7, 3, 1'b0, e, ec);
    wait_until(ec);
    chk("100/7 LO", LO, 32'd14);
    chk("100/7 HI", HI, 32'd2);
    chk("100/7 done edge", 32'(last_done_cyc - e + 1), 32'd7);

    // divide by zero, unsigned and signed
    issue(1'b0, 32'd55, 32'd0, 1, 1'b0, e, ec);
    wait_until(ec + 1);
    issue(1'b1, 32'hFFFFFFF9, 32'd0, 1, 1'b0, e, ec);
    wait_until(ec + 1);
    chk("rt0 LO kept", LO, 32'd14);
    chk("rt0 HI kept", HI, 32'd2);

    // DIV -7/2
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1, 1'b0, e, ec);
    wait_until(ec);
    chk("-7/2 DIV_A", DIV_A, 32'd7);
    chk("-7/2 DIV_B", DIV_B, 32'd2);
    chk("-7/2 LO", LO, 32'hFFFFFFFD);
    chk("-7/2 HI", HI, 32'hFFFFFFFF);

    // DIV 7/-2
    issue(1'b1, 32'd7, 32'hFFFFFFFE, 2, 1'b0, e, ec);
    wait_until(ec);
    chk("7/-2 LO", LO, 32'hFFFFFFFD);
    chk("7/-2 HI", HI, 32'd1);

    // DIV 0x80000000 / -1
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 4, 1'b0, e, ec);
    wait_until(ec);
    chk("min/-1 LO", LO, 32'h80000000);
    chk("min/-1 HI", HI, 32'h0);

    // DIVU large dividend, with requests pulsed while busy
    issue(1'b0, 32'hFFFFFFFF, 32'h10, 6, 1'b0, e, ec);
    pulse_req(1'b0, 32'd5, 32'd0);
    pulse_req(1'b1, 32'd9, 32'd3);
    wait_until(ec);
    chk("ignore LO", LO, 32'h0FFFFFFF);
    chk("ignore HI", HI, 32'h0000000F);

    // watchdog expiry: divider never completes
    issue(1'b0, 32'd50, 32'd5, 1, 1'b1, e, ec);
    wait_until(ec);
    chk("tmo edge", 32'(last_tout_cyc - e + 1), 32'd42);
    chk("tmo LO kept", LO, 32'h0FFFFFFF);
    chk("tmo HI kept", HI, 32'h0000000F);

    // DIV_END arriving on the last WAIT edge completes normally
    issue(1'b0, 32'd1000, 32'd10, int'(TMO) - 1, 1'b0, e, ec);
    wait_until(ec);
    chk("late LO", LO, 32'd100);
    chk("late HI", HI, 32'd0);
    chk("late done edge", 32'(last_done_cyc - e + 1), 32'd43);

    // reset mid-WAIT
    issue(1'b0, 32'd77, 32'd3, 1, 1'b1, e, ec);
    repeat (5) @(posedge clock);
    #3; reset = 1'b0; #1;
    chk("mid rst BUSY", 32'(BUSY), 32'h0);
    chk("mid rst LO", LO, 32'h0);
    chk("mid rst DIV_A", DIV_A, 32'h0);
    chk("mid rst DIV_B", DIV_B, 32'h0);
    model_reset();
    @(posedge clock); #2; reset = 1'b1;
    issue(1'b0, 32'd100, 32'd7, 2, 1'b0, e, ec);
    wait_until(ec);
    chk("post rst LO", LO, 32'd14);
    chk("post rst HI", HI, 32'd2);

    // reset during the START cycle drops DIV_START at once
    issue(1'b0, 32'd20, 32'd3, 2, 1'b0, e, ec);
    chk("start hi", 32'(DIV_START), 32'h1);
    #1; reset = 1'b0; #1;
    chk("start rst DIV_START", 32'(DIV_START), 32'h0);
    chk("start rst HI", HI, 32'h0);
    model_reset();
    @(posedge clock); #2; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_controller.md
# div_controller

Sequencing controller that sits between the CPU control unit and the unsigned restoring `divisor` datapath. It accepts a one-cycle DIV/DIVU request and screens out divide-by-zero before the divider is started. It converts signed operands to magnitudes, pulses `DIV_START`, waits for `DIV_END` under a watchdog, applies the sign fix-up, and holds the architectural HI/LO results. While it works it stalls the CPU through `BUSY`.

## Interface
- `TIMEOUT`, default 40: maximum number of WAIT cycles before the operation is abandoned. Must be ≥ 2.
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 forces every register to its reset value immediately.
- `DIV_REQ`  in  1  one-cycle request from the control unit. Sampled only in IDLE.
- `DIV_SIGNED`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `DIV_REQ`.
- `RS`  in  32  dividend, sampled with `DIV_REQ`.
- `RT`  in  32  divisor, sampled with `DIV_REQ`.
- `DIV_START`  out  1  start pulse to the divider.
- `DIV_A`  out  32  dividend magnitude to the divider.
- `DIV_B`  out  32  divisor magnitude to the divider.
- `DIV_END`  in  1  divider done flag. Level signal; it stays high until the next start.
- `DIV_HI`  in  32  divider remainder.
- `DIV_LO`  in  32  divider quotient.
- `HI`  out  32  architectural remainder register.
- `LO`  out  32  architectural quotient register.
- `BUSY`  out  1  high whenever state ≠ IDLE; used as the CPU stall.
- `DONE`  out  1  one-cycle pulse; `HI`/`LO` are valid and updated during it.
- `DIV_ZERO`  out  1  one-cycle exception pulse.
- `DIV_TIMEOUT`  out  1  one-cycle error pulse.

## Operation
- **Reset values:** state IDLE; all outputs 0, including `HI`, `LO` and `DIV_A`/`DIV_B`; timer 0.
- **IDLE**
  - `DIV_REQ`=1 and `RT`=0: `DIV_ZERO`=1 for the next cycle. State stays IDLE. The divider is never started and `HI`/`LO` are unchanged.
  - `DIV_REQ`=1 and `RT`≠0: latch `sa` = `DIV_SIGNED` & `RS[31]` and `sb` = `DIV_SIGNED` & `RT[31]`. Load `DIV_A` = `sa` ? −`RS` : `RS` and `DIV_B` = `sb` ? −`RT` : `RT` (32-bit two's-complement negate). Go to START.
  - All other cycles: remain in IDLE.
- **START:** `DIV_START`=1 for exactly this one cycle. Clear the timer and go to WAIT.
- **WAIT**
  - `DIV_A`/`DIV_B` are held stable throughout.
  - `DIV_END`=1: go to FIX.
  - Otherwise the timer increments. If the timer equals `TIMEOUT`−1 at an edge with `DIV_END`=0, go to IDLE and set `DIV_TIMEOUT`=1 for one cycle; `HI`/`LO` are unchanged.
  - If `DIV_END` and the timeout occur at the same edge, `DIV_END` wins.
- **FIX:** write `LO` = (`sa`^`sb`) ? −`DIV_LO` : `DIV_LO` and `HI` = `sa` ? −`DIV_HI` : `DIV_HI`. Go to DONE.
- **DONE:** `DONE`=1. Go to IDLE.
- **Arithmetic rules:**
  - All arithmetic is 32-bit and wraps.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives `LO`=0x80000000 and `HI`=0. This falls out of the magnitude path with no special case.
- **Requests while BUSY:** `DIV_REQ` is ignored in every state except IDLE; the operation in flight is unaffected.
- **Reset mid-operation:** return to IDLE asynchronously and drop `DIV_START` immediately. A divider left running is harmless, because the next START reloads it.

## Timing
- Edge numbering: `DIV_REQ` is sampled at edge 1; `DIV_START` is high between edges 1 and 2. Let the divider raise `DIV_END` after edge 2+L.
- Sequence:
  - WAIT samples `DIV_END` at edge 3+L and moves to FIX.
  - `HI`/`LO` are written at edge 4+L.
  - `DONE` is high from edge 4+L to edge 5+L.
  - `BUSY` is high from edge 1 to edge 5+L.
- Total latency is L+4 cycles from request to `DONE`, and controller overhead is fixed at 4 cycles.
- `DIV_END` is already low in WAIT, because the divider clears it on the same edge that samples `DIV_START`. A stale `DIV_END` from a previous operation is therefore never seen.
- `DIV_ZERO` is high from edge 1 to edge 2; `BUSY` stays 0 throughout.
- Timeout: WAIT lasts exactly `TIMEOUT` cycles. `DIV_TIMEOUT` is high for the cycle after the last WAIT edge, and `BUSY` falls on the same edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **DIVU 100/7:** with the bench divider model (any L), expect `LO`=14, `HI`=2, `DONE` one cycle at edge L+4, and `DIV_START` high exactly one cycle.
- **DIV −7/2:** `DIV_A`=7, `DIV_B`=2. Expect `LO`=0xFFFFFFFD and `HI`=0xFFFFFFFF. DIV 7/−2 gives `LO`=0xFFFFFFFD and `HI`=1.
- **DIV 0x80000000 / 0xFFFFFFFF:** expect `LO`=0x80000000 and `HI`=0, with no exception.
- **`RT`=0 (both DIV and DIVU):** expect a `DIV_ZERO` pulse one cycle after the request. `DIV_START` never rises, `BUSY` stays 0, and `HI`/`LO` keep their prior values (e.g. 14/2).
- **Timeout:** a model that never asserts `DIV_END` with `TIMEOUT`=40 gives a `DIV_TIMEOUT` pulse 42 cycles after the request, `BUSY` low, and `HI`/`LO` unchanged. A model with `DIV_END` arriving on the last WAIT edge completes normally.
- **Reset and ignored requests:** asserting `reset`=0 mid-WAIT clears all outputs immediately, and a fresh 100/7 afterwards gives 14/2. Pulsing `DIV_REQ` with other operands while `BUSY` must not change the in-flight result.
